// File: rtl/systolic_tile_scheduler.sv
// Walks the DIM x DIM output-tile grid of one C = A*W job, issuing one tile command at a time
// to the array core and returning a single host response with the executed tile count.
module systolic_tile_scheduler #(
   parameter int SYSTOLIC_ARRAY_DIM = 8,
   parameter int DATA_WIDTH_BITS    = 16,
   parameter int TILE_CNT_BITS      = 16
) (
   input  logic                         clock,
   input  logic                         areset,
   input  logic                         host_cmd_valid,
   output logic                         host_cmd_ready,
   input  logic [63:0]                  host_cmd_act_addr,
   input  logic [63:0]                  host_cmd_wgt_addr,
   input  logic [63:0]                  host_cmd_out_addr,
   input  logic [TILE_CNT_BITS-1:0]     host_cmd_row_tiles,
   input  logic [TILE_CNT_BITS-1:0]     host_cmd_col_tiles,
   input  logic [19:0]                  host_cmd_inner_dimension,
   output logic                         host_resp_valid,
   input  logic                         host_resp_ready,
   output logic [2*TILE_CNT_BITS-1:0]   host_resp_tiles,
   output logic                         core_cmd_valid,
   input  logic                         core_cmd_ready,
   output logic [63:0]                  core_cmd_act_addr,
   output logic [63:0]                  core_cmd_wgt_addr,
   output logic [63:0]                  core_cmd_out_addr,
   output logic [19:0]                  core_cmd_inner_dimension,
   input  logic                         core_resp_valid,
   output logic                         core_resp_ready,
   output logic                         busy
);

   localparam int BYTES = DATA_WIDTH_BITS / 8;
   localparam logic [63:0] DIM_BYTES = 64'(SYSTOLIC_ARRAY_DIM * BYTES);
   localparam logic [63:0] OSTRIDE   = 64'(SYSTOLIC_ARRAY_DIM * SYSTOLIC_ARRAY_DIM * BYTES);
   localparam logic [TILE_CNT_BITS-1:0]   T_ZERO   = TILE_CNT_BITS'(0);
   localparam logic [TILE_CNT_BITS-1:0]   T_ONE    = TILE_CNT_BITS'(1);
   localparam logic [2*TILE_CNT_BITS-1:0] DONE_ONE = (2*TILE_CNT_BITS)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t state_r;
   state_t next_state;

   logic host_cmd_ready_r, host_resp_valid_r, core_cmd_valid_r, core_resp_ready_r, busy_r;
   logic host_cmd_ready_n, host_resp_valid_n, core_cmd_valid_n, core_resp_ready_n, busy_n;

   logic [63:0]                act_r, wgt_r, out_r, wgt_base_r, stride_r;
   logic [TILE_CNT_BITS-1:0]   rows_r, cols_r, i_r, j_r;
   logic [19:0]                k_r;
   logic [2*TILE_CNT_BITS-1:0] done_r;

   logic host_fire, core_cmd_fire, core_resp_fire, empty_cmd, last_col, last_tile;

   // Fires are qualified by the registered handshake outputs so nothing is taken while they read 0.
   assign host_fire      = host_cmd_ready_r && host_cmd_valid;
   assign core_cmd_fire  = core_cmd_valid_r && core_cmd_ready;
   assign core_resp_fire = core_resp_ready_r && core_resp_valid;
   assign empty_cmd      = (host_cmd_row_tiles == T_ZERO) || (host_cmd_col_tiles == T_ZERO) ||
                           (host_cmd_inner_dimension == 20'd0);
   assign last_col       = (j_r == cols_r - T_ONE);
   assign last_tile      = last_col && (i_r == rows_r - T_ONE);

   // State register
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state;
      end
   end

   // Next-state decode
   always_comb begin
      next_state = state_r;
      case (state_r)
         S_IDLE: begin
            if (host_fire) begin
               next_state = empty_cmd ? S_RESP : S_ISSUE;
            end else begin
               next_state = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (core_cmd_fire) begin
               next_state = S_WAIT;
            end else begin
               next_state = S_ISSUE;
            end
         end
         S_WAIT: begin
            if (core_resp_fire) begin
               next_state = last_tile ? S_RESP : S_ISSUE;
            end else begin
               next_state = S_WAIT;
            end
         end
         S_RESP: begin
            if (host_resp_ready) begin
               next_state = S_IDLE;
            end else begin
               next_state = S_RESP;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Output decode from the next state, so the registered outputs line up with the state register
   always_comb begin
      host_cmd_ready_n  = 1'b0;
      host_resp_valid_n = 1'b0;
      core_cmd_valid_n  = 1'b0;
      core_resp_ready_n = 1'b0;
      busy_n            = 1'b1;
      case (next_state)
         S_IDLE: begin
            host_cmd_ready_n = 1'b1;
            busy_n           = 1'b0;
         end
         S_ISSUE: core_cmd_valid_n  = 1'b1;
         S_WAIT:  core_resp_ready_n = 1'b1;
         S_RESP:  host_resp_valid_n = 1'b1;
         default: busy_n = 1'b0;
      endcase
   end

   // Output register; everything reads 0 while areset is held
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         host_cmd_ready_r  <= 1'b0;
         host_resp_valid_r <= 1'b0;
         core_cmd_valid_r  <= 1'b0;
         core_resp_ready_r <= 1'b0;
         busy_r            <= 1'b0;
      end else begin
         host_cmd_ready_r  <= host_cmd_ready_n;
         host_resp_valid_r <= host_resp_valid_n;
         core_cmd_valid_r  <= core_cmd_valid_n;
         core_resp_ready_r <= core_resp_ready_n;
         busy_r            <= busy_n;
      end
   end

   // Job latch and incremental tile walk (columns inner, rows outer)
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         act_r      <= 64'd0;
         wgt_r      <= 64'd0;
         out_r      <= 64'd0;
         wgt_base_r <= 64'd0;
         stride_r   <= 64'd0;
         rows_r     <= T_ZERO;
         cols_r     <= T_ZERO;
         i_r        <= T_ZERO;
         j_r        <= T_ZERO;
         k_r        <= 20'd0;
         done_r     <= '0;
      end else if (host_fire) begin
         act_r      <= host_cmd_act_addr;
         wgt_r      <= host_cmd_wgt_addr;
         out_r      <= host_cmd_out_addr;
         wgt_base_r <= host_cmd_wgt_addr;
         stride_r   <= DIM_BYTES * 64'(host_cmd_inner_dimension);
         rows_r     <= host_cmd_row_tiles;
         cols_r     <= host_cmd_col_tiles;
         i_r        <= T_ZERO;
         j_r        <= T_ZERO;
         k_r        <= host_cmd_inner_dimension;
         done_r     <= '0;
      end else if (core_resp_fire) begin
         done_r <= done_r + DONE_ONE;
         if (last_tile) begin
            j_r <= j_r;
         end else if (!last_col) begin
            j_r   <= j_r + T_ONE;
            wgt_r <= wgt_r + stride_r;
            out_r <= out_r + OSTRIDE;
         end else begin
            j_r   <= T_ZERO;
            i_r   <= i_r + T_ONE;
            wgt_r <= wgt_base_r;
            act_r <= act_r + stride_r;
            out_r <= out_r + OSTRIDE;
         end
      end else begin
         done_r <= done_r;
      end
   end

   assign host_cmd_ready           = host_cmd_ready_r;
   assign host_resp_valid          = host_resp_valid_r;
   assign host_resp_tiles          = done_r;
   assign core_cmd_valid           = core_cmd_valid_r;
   assign core_cmd_act_addr        = act_r;
   assign core_cmd_wgt_addr        = wgt_r;
   assign core_cmd_out_addr        = out_r;
   assign core_cmd_inner_dimension = k_r;
   assign core_resp_ready          = core_resp_ready_r;
   assign busy                     = busy_r;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Directed self-checking bench for systolic_tile_scheduler (DIM=8, 16-bit elements).
module tb_systolic_tile_scheduler;

   logic        clock = 1'b0;
   logic        areset;
   logic        host_cmd_valid, host_cmd_ready;
   logic [63:0] host_cmd_act_addr, host_cmd_wgt_addr, host_cmd_out_addr;
   logic [15:0] host_cmd_row_tiles, host_cmd_col_tiles;
   logic [19:0] host_cmd_inner_dimension;
   logic        host_resp_valid, host_resp_ready;
   logic [31:0] host_resp_tiles;
   logic        core_cmd_valid, core_cmd_ready;
   logic [63:0] core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr;
   logic [19:0] core_cmd_inner_dimension;
   logic        core_resp_valid, core_resp_ready, busy;

   int checks = 0;
   int fails  = 0;

   always #5 clock = ~clock;

   systolic_tile_scheduler #(
      .SYSTOLIC_ARRAY_DIM(8),
      .DATA_WIDTH_BITS(16),
      .TILE_CNT_BITS(16)
   ) dut (
      .clock(clock),
      .areset(areset),
      .host_cmd_valid(host_cmd_valid),
      .host_cmd_ready(host_cmd_ready),
      .host_cmd_act_addr(host_cmd_act_addr),
      .host_cmd_wgt_addr(host_cmd_wgt_addr),
      .host_cmd_out_addr(host_cmd_out_addr),
      .host_cmd_row_tiles(host_cmd_row_tiles),
      .host_cmd_col_tiles(host_cmd_col_tiles),
      .host_cmd_inner_dimension(host_cmd_inner_dimension),
      .host_resp_valid(host_resp_valid),
      .host_resp_ready(host_resp_ready),
      .host_resp_tiles(host_resp_tiles),
      .core_cmd_valid(core_cmd_valid),
      .core_cmd_ready(core_cmd_ready),
      .core_cmd_act_addr(core_cmd_act_addr),
      .core_cmd_wgt_addr(core_cmd_wgt_addr),
      .core_cmd_out_addr(core_cmd_out_addr),
      .core_cmd_inner_dimension(core_cmd_inner_dimension),
      .core_resp_valid(core_resp_valid),
      .core_resp_ready(core_resp_ready),
      .busy(busy)
   );

   // Presents a host command and returns at the falling edge after it was accepted.
   task automatic send_cmd(input logic [63:0] a, input logic [63:0] w, input logic [63:0] o,
                           input logic [15:0] r, input logic [15:0] c, input logic [19:0] k,
                           output bit ok);
      ok = 1'b0;
      @(negedge clock);
      host_cmd_valid = 1'b1;
      host_cmd_act_addr = a;
      host_cmd_wgt_addr = w;
      host_cmd_out_addr = o;
      host_cmd_row_tiles = r;
      host_cmd_col_tiles = c;
      host_cmd_inner_dimension = k;
      for (int n = 0; n < 20; n++) begin
         if (host_cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (ok) begin
         @(posedge clock);
         @(negedge clock);
      end
      host_cmd_valid = 1'b0;
   endtask

   // Samples the presented tile command, accepts it, then returns a core response.
   task automatic run_one_tile(output logic v, output logic [63:0] a, output logic [63:0] w,
                               output logic [63:0] o, output logic [19:0] k, output logic rr);
      v = core_cmd_valid;
      a = core_cmd_act_addr;
      w = core_cmd_wgt_addr;
      o = core_cmd_out_addr;
      k = core_cmd_inner_dimension;
      core_cmd_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      core_cmd_ready = 1'b0;
      rr = core_resp_ready;
      core_resp_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      core_resp_valid = 1'b0;
   endtask

   // Samples and accepts the host response; reports whether the scheduler is idle afterwards.
   task automatic take_resp(output logic v, output logic [31:0] t, output logic idle_after);
      v = host_resp_valid;
      t = host_resp_tiles;
      host_resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      host_resp_ready = 1'b0;
      idle_after = host_cmd_ready && !busy && !host_resp_valid && !core_cmd_valid;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({host_cmd_ready, host_resp_valid, core_cmd_valid, core_resp_ready, busy} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {host_cmd_ready, host_resp_valid, core_cmd_valid, core_resp_ready, busy});
      end
      checks++;
      if ({core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr, host_resp_tiles} !== 224'd0) begin
         fails++;
         $display("FAIL reset_data: act=%h wgt=%h out=%h tiles=%0d want all 0",
                  core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr, host_resp_tiles);
      end
      @(negedge clock);
      @(negedge clock);
      areset = 1'b0;
      @(negedge clock);
      checks++;
      if ({host_cmd_ready, busy} !== 2'b10) begin
         fails++;
         $display("FAIL reset_release: ready,busy=%b want 10", {host_cmd_ready, busy});
      end
   endtask

   task automatic test_single_tile;
      bit ok;
      logic v, rr, idle;
      logic [63:0] a, w, o;
      logic [19:0] k;
      logic [31:0] t;
      send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd1, 16'd1, 20'd32, ok);
      checks++;
      if (ok !== 1'b1) begin
         fails++;
         $display("FAIL single_accept: accepted=%b want 1", ok);
      end
      checks++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL single_busy: got %b want 1", busy);
      end
      run_one_tile(v, a, w, o, k, rr);
      checks++;
      if ({v, a, w, o, k, rr} !== {1'b1, 64'h1000, 64'h2000, 64'h3000, 20'd32, 1'b1}) begin
         fails++;
         $display("FAIL single_cmd: v=%b act=%h wgt=%h out=%h k=%0d rr=%b want 1/1000/2000/3000/32/1",
                  v, a, w, o, k, rr);
      end
      take_resp(v, t, idle);
      checks++;
      if ({v, t, idle} !== {1'b1, 32'd1, 1'b1}) begin
         fails++;
         $display("FAIL single_resp: v=%b tiles=%0d idle=%b want 1/1/1", v, t, idle);
      end
   endtask

   task automatic test_grid;
      bit ok;
      logic v, rr, idle;
      logic [63:0] a, w, o;
      logic [19:0] k;
      logic [31:0] t;
      logic [63:0] ea [6] = '{64'h1000, 64'h1000, 64'h1000, 64'h1200, 64'h1200, 64'h1200};
      logic [63:0] ew [6] = '{64'h2000, 64'h2200, 64'h2400, 64'h2000, 64'h2200, 64'h2400};
      logic [63:0] eo [6] = '{64'h3000, 64'h3080, 64'h3100, 64'h3180, 64'h3200, 64'h3280};
      send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd2, 16'd3, 20'd32, ok);
      for (int n = 0; n < 6; n++) begin
         run_one_tile(v, a, w, o, k, rr);
         checks++;
         if ({v, a, w, o, k, rr} !== {1'b1, ea[n], ew[n], eo[n], 20'd32, 1'b1}) begin
            fails++;
            $display("FAIL grid_tile%0d: v=%b act=%h wgt=%h out=%h k=%0d rr=%b want 1/%h/%h/%h/32/1",
                     n, v, a, w, o, k, rr, ea[n], ew[n], eo[n]);
         end
      end
      take_resp(v, t, idle);
      checks++;
      if ({v, t, idle} !== {1'b1, 32'd6, 1'b1}) begin
         fails++;
         $display("FAIL grid_resp: v=%b tiles=%0d idle=%b want 1/6/1", v, t, idle);
      end
   endtask

   task automatic test_empty_jobs;
      bit ok;
      logic v, idle;
      logic [31:0] t;
      logic [15:0] rows [3] = '{16'd0, 16'd2, 16'd2};
      logic [15:0] cols [3] = '{16'd3, 16'd0, 16'd3};
      logic [19:0] kk   [3] = '{20'd32, 20'd32, 20'd0};
      for (int n = 0; n < 3; n++) begin
         send_cmd(64'h1000, 64'h2000, 64'h3000, rows[n], cols[n], kk[n], ok);
         checks++;
         if ({core_cmd_valid, host_resp_valid, host_resp_tiles} !== {1'b0, 1'b1, 32'd0}) begin
            fails++;
            $display("FAIL empty%0d: core_valid=%b resp_valid=%b tiles=%0d want 0/1/0",
                     n, core_cmd_valid, host_resp_valid, host_resp_tiles);
         end
         take_resp(v, t, idle);
         checks++;
         if (idle !== 1'b1) begin
            fails++;
            $display("FAIL empty%0d_idle: got %b want 1", n, idle);
         end
      end
   endtask

   task automatic test_core_stall;
      bit ok;
      logic v, idle;
      logic [31:0] t;
      bit stable;
      send_cmd(64'h4000, 64'h5000, 64'h6000, 16'd1, 16'd1, 20'd16, ok);
      core_resp_valid = 1'b1;
      stable = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(posedge clock);
         @(negedge clock);
         if ({core_cmd_valid, core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr,
              core_cmd_inner_dimension, core_resp_ready, host_resp_valid} !==
             {1'b1, 64'h4000, 64'h5000, 64'h6000, 20'd16, 1'b0, 1'b0}) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         fails++;
         $display("FAIL stall_hold: fields stable=%b want 1 (act=%h wgt=%h out=%h)",
                  stable, core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr);
      end
      core_cmd_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      core_cmd_ready = 1'b0;
      checks++;
      if ({core_cmd_valid, core_resp_ready, host_resp_valid} !== 3'b010) begin
         fails++;
         $display("FAIL stall_early_resp: cv,rr,hv=%b want 010",
                  {core_cmd_valid, core_resp_ready, host_resp_valid});
      end
      @(posedge clock);
      @(negedge clock);
      core_resp_valid = 1'b0;
      take_resp(v, t, idle);
      checks++;
      if ({v, t, idle} !== {1'b1, 32'd1, 1'b1}) begin
         fails++;
         $display("FAIL stall_resp: v=%b tiles=%0d idle=%b want 1/1/1", v, t, idle);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      bit held;
      logic v, rr, idle;
      logic [63:0] a, w, o;
      logic [19:0] k;
      logic [31:0] t;
      send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd1, 16'd2, 20'd32, ok);
      run_one_tile(v, a, w, o, k, rr);
      run_one_tile(v, a, w, o, k, rr);
      host_cmd_valid = 1'b1;
      host_cmd_act_addr = 64'h7000;
      host_cmd_wgt_addr = 64'h8000;
      host_cmd_out_addr = 64'h9000;
      host_cmd_row_tiles = 16'd1;
      host_cmd_col_tiles = 16'd1;
      host_cmd_inner_dimension = 20'd8;
      held = 1'b1;
      for (int n = 0; n < 4; n++) begin
         if ({host_resp_valid, host_resp_tiles, host_cmd_ready} !== {1'b1, 32'd2, 1'b0}) held = 1'b0;
         @(posedge clock);
         @(negedge clock);
      end
      checks++;
      if (held !== 1'b1) begin
         fails++;
         $display("FAIL b2b_hold: held=%b resp_valid=%b tiles=%0d cmd_ready=%b want 1/1/2/0",
                  held, host_resp_valid, host_resp_tiles, host_cmd_ready);
      end
      host_resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      host_resp_ready = 1'b0;
      checks++;
      if ({host_resp_valid, host_cmd_ready} !== 2'b01) begin
         fails++;
         $display("FAIL b2b_release: resp_valid,cmd_ready=%b want 01", {host_resp_valid, host_cmd_ready});
      end
      @(posedge clock);
      @(negedge clock);
      host_cmd_valid = 1'b0;
      run_one_tile(v, a, w, o, k, rr);
      checks++;
      if ({v, a, w, o, k} !== {1'b1, 64'h7000, 64'h8000, 64'h9000, 20'd8}) begin
         fails++;
         $display("FAIL b2b_new_job: v=%b act=%h wgt=%h out=%h k=%0d want 1/7000/8000/9000/8",
                  v, a, w, o, k);
      end
      take_resp(v, t, idle);
      checks++;
      if ({v, t, idle} !== {1'b1, 32'd1, 1'b1}) begin
         fails++;
         $display("FAIL b2b_resp: v=%b tiles=%0d idle=%b want 1/1/1", v, t, idle);
      end
   endtask

   task automatic test_async_reset;
      bit ok;
      logic v, rr, idle;
      logic [63:0] a, w, o;
      logic [19:0] k;
      logic [31:0] t;
      send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd2, 16'd2, 20'd32, ok);
      run_one_tile(v, a, w, o, k, rr);
      checks++;
      if ({core_cmd_valid, core_cmd_wgt_addr, core_cmd_out_addr} !== {1'b1, 64'h2200, 64'h3080}) begin
         fails++;
         $display("FAIL rst_pre_tile1: v=%b wgt=%h out=%h want 1/2200/3080",
                  core_cmd_valid, core_cmd_wgt_addr, core_cmd_out_addr);
      end
      core_cmd_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      core_cmd_ready = 1'b0;
      #2 areset = 1'b1;
      #1;
      checks++;
      if ({host_cmd_ready, host_resp_valid, core_cmd_valid, core_resp_ready, busy} !== 5'b00000) begin
         fails++;
         $display("FAIL rst_async_ctrl: got %b want 00000",
                  {host_cmd_ready, host_resp_valid, core_cmd_valid, core_resp_ready, busy});
      end
      checks++;
      if ({core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr, core_cmd_inner_dimension,
           host_resp_tiles} !== 244'd0) begin
         fails++;
         $display("FAIL rst_async_data: act=%h wgt=%h out=%h k=%0d tiles=%0d want all 0",
                  core_cmd_act_addr, core_cmd_wgt_addr, core_cmd_out_addr,
                  core_cmd_inner_dimension, host_resp_tiles);
      end
      @(negedge clock);
      areset = 1'b0;
      @(negedge clock);
      checks++;
      if ({host_cmd_ready, busy, core_cmd_valid, core_resp_ready} !== 4'b1000) begin
         fails++;
         $display("FAIL rst_after: ready,busy,cv,rr=%b want 1000",
                  {host_cmd_ready, busy, core_cmd_valid, core_resp_ready});
      end
      send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd1, 16'd1, 20'd32, ok);
      run_one_tile(v, a, w, o, k, rr);
      checks++;
      if ({ok, v, a, w, o, k} !== {1'b1, 1'b1, 64'h1000, 64'h2000, 64'h3000, 20'd32}) begin
         fails++;
         $display("FAIL rst_fresh_cmd: ok=%b v=%b act=%h wgt=%h out=%h k=%0d want 1/1/1000/2000/3000/32",
                  ok, v, a, w, o, k);
      end
      take_resp(v, t, idle);
      checks++;
      if ({v, t, idle} !== {1'b1, 32'd1, 1'b1}) begin
         fails++;
         $display("FAIL rst_fresh_resp: v=%b tiles=%0d idle=%b want 1/1/1", v, t, idle);
      end
   endtask

   initial begin
      areset = 1'b1;
      host_cmd_valid = 1'b0;
      host_cmd_act_addr = 64'd0;
      host_cmd_wgt_addr = 64'd0;
      host_cmd_out_addr = 64'd0;
      host_cmd_row_tiles = 16'd0;
      host_cmd_col_tiles = 16'd0;
      host_cmd_inner_dimension = 20'd0;
      host_resp_ready = 1'b0;
      core_cmd_ready = 1'b0;
      core_resp_valid = 1'b0;
      test_reset();
      test_single_tile();
      test_grid();
      test_empty_jobs();
      test_core_stall();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/systolic_tile_scheduler.md
Name: systolic_tile_scheduler

Overview:
- Sequences one large matrix multiply, C[M×N] = A[M×K]·W[K×N], as a series of DIM×DIM output-tile commands to the systolic array core's cmd_0/resp_0 interface.
- Accepts one host command, walks the tile grid, and computes per-tile activation, weight and output addresses incrementally.
- Keeps exactly one tile command outstanding and returns one host response when the whole grid is done.
- Sits between the host command router and the array core.

Parameters:
- SYSTOLIC_ARRAY_DIM, 8, array edge length; tile is DIM×DIM.
- DATA_WIDTH_BITS, 16, element width; multiple of 8; BYTES = DATA_WIDTH_BITS/8.
- TILE_CNT_BITS, 16, width of tile-count fields.

Ports:
- clock  in  1  sole clock.
- areset  in  1  asynchronous, active-high reset.
- host_cmd_valid  in  1  host command valid.
- host_cmd_ready  out  1  scheduler can accept a command.
- host_cmd_act_addr  in  64  base address of A (row-tile major).
- host_cmd_wgt_addr  in  64  base address of W (column-tile major).
- host_cmd_out_addr  in  64  base address of C (tiles linear, row-major over the tile grid).
- host_cmd_row_tiles  in  TILE_CNT_BITS  M/DIM.
- host_cmd_col_tiles  in  TILE_CNT_BITS  N/DIM.
- host_cmd_inner_dimension  in  20  K.
- host_resp_valid  out  1  whole job complete.
- host_resp_ready  in  1  host accepts the response.
- host_resp_tiles  out  2*TILE_CNT_BITS  number of tiles executed.
- core_cmd_valid  out  1  tile command valid.
- core_cmd_ready  in  1  core accepts the tile command.
- core_cmd_act_addr  out  64  tile activation address.
- core_cmd_wgt_addr  out  64  tile weight address.
- core_cmd_out_addr  out  64  tile output address.
- core_cmd_inner_dimension  out  20  K, held for the whole job.
- core_resp_valid  in  1  tile finished.
- core_resp_ready  out  1  scheduler consumes the tile response.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
  - IDLE: host_cmd_ready=1. On fire, latch all fields and compute the strides:
    - ASTRIDE = WSTRIDE = DIM·K·BYTES
    - OSTRIDE = DIM·DIM·BYTES
    - All address arithmetic is 64-bit modulo 2^64.
    - Reset counters i=0, j=0 and done_cnt=0. Set act_r=act_addr, wgt_r=wgt_addr, out_r=out_addr.
    - If row_tiles==0, col_tiles==0 or K==0, go to RESP and issue no tile. Otherwise go to ISSUE.
  - ISSUE: core_cmd_valid=1, core_cmd_* = act_r / wgt_r / out_r / K. Fields stay stable until core_cmd_ready. On fire, go to WAIT. Valid is never dropped before fire.
  - WAIT: core_resp_ready=1. On core_resp_valid, increment done_cnt.
    - If i==row_tiles-1 and j==col_tiles-1, go to RESP.
    - Else if j<col_tiles-1: j++, wgt_r+=WSTRIDE, out_r+=OSTRIDE, go to ISSUE.
    - Else: j=0, i++, wgt_r=latched wgt base, act_r+=ASTRIDE, out_r+=OSTRIDE, go to ISSUE.
  - RESP: host_resp_valid=1, host_resp_tiles=done_cnt, held until host_resp_ready. Then go to IDLE.
- Latency:
  - IDLE→ISSUE takes 1 cycle after host fire.
  - After a core response, the next core_cmd_valid asserts 1 cycle later.
  - host_resp_valid asserts the cycle after the final core response.
- Iteration order is j inner (columns), i outer. Output tiles are written in linear address order.
- Handshake rules:
  - host_cmd_ready=0 outside IDLE, so commands are never dropped, only back-pressured.
  - core_resp_ready=0 outside WAIT, so a stray core response stays pending.
  - core_resp_valid arriving in the same cycle as core_cmd fire is not consumed that cycle.
- Reset (asynchronous, any state):
  - Go to IDLE.
  - All outputs 0: host_cmd_ready=0 while areset is asserted, then 1 from IDLE; all valids=0, all addresses=0, busy=0, host_resp_tiles=0.
  - Internal registers are cleared.
  - An in-flight tile is abandoned; the system resets the core on the same areset.
- The outstanding count to the core is never greater than 1.

Test Plan:
- 1×1 job, K=32, bases 0x1000/0x2000/0x3000 -> one core cmd with act=0x1000, wgt=0x2000, out=0x3000, K=32; after core resp, host_resp_valid with tiles=1.
- 2×3 job, same bases, DIM=8, 16-bit elements, K=32 (ASTRIDE=0x200, OSTRIDE=0x80) -> act/wgt/out sequence:
  - 1000/2000/3000
  - 1000/2200/3080
  - 1000/2400/3100
  - 1200/2000/3180
  - 1200/2200/3200
  - 1200/2400/3280
  - then tiles=6.
- row_tiles=0 (also col_tiles=0, and separately K=0) -> no core_cmd_valid; host_resp_valid 1 cycle after accept with tiles=0.
- core_cmd_ready held low 5 cycles, then core_resp_valid held high during ISSUE -> core_cmd fields stable across the stall; the early response is not consumed until WAIT.
- host_resp_ready low 4 cycles with a new host_cmd_valid asserted -> host_resp_valid and tiles held; host_cmd_ready stays 0 until the response is accepted, then the new job starts.
- areset pulsed asynchronously in WAIT of a 2×2 job -> outputs zero immediately; after release, state is IDLE, host_cmd_ready=1, and a fresh 1×1 job completes normally.
